// File: rtl/display_pkg.sv
// Shared display definitions: 7-segment patterns, BCD decode and a width helper.
package display_pkg;

    // Active-high segment patterns, bit0 = A (top) ... bit6 = G (middle)
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Largest legal BCD digit value
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_t;

    // Decode one BCD digit; any non-BCD code shows as blank
    function automatic logic [6:0] bcd_to_seg(input bcd_t bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Ceiling log2 with a floor of 1 bit, so a counter always has a register
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((32'sd1 <<< width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain: up/down step on carry/borrow-in, parallel load.
module bcd_digit
    import display_pkg::*;
(
    input  logic tg,
    input  logic rst_n,
    input  logic ci,
    input  logic up,
    input  logic load,
    input  bcd_t ld_val,
    output bcd_t q,
    output logic co
);

    bcd_t digit_r;
    bcd_t next_s;
    bcd_t ld_clean_s;

    // Non-BCD load codes are stored as zero
    always_comb begin
        ld_clean_s = 4'd0;
        if (ld_val > BCD_MAX) begin
            ld_clean_s = 4'd0;
        end else begin
            ld_clean_s = ld_val;
        end
    end

    // Next digit value and carry/borrow-out when this digit is stepped
    always_comb begin
        next_s = digit_r;
        co     = 1'b0;
        if (ci) begin
            if (up) begin
                if (digit_r >= BCD_MAX) begin
                    next_s = 4'd0;
                    co     = 1'b1;
                end else begin
                    next_s = digit_r + 4'd1;
                    co     = 1'b0;
                end
            end else begin
                if (digit_r == 4'd0) begin
                    next_s = BCD_MAX;
                    co     = 1'b1;
                end else begin
                    next_s = digit_r - 4'd1;
                    co     = 1'b0;
                end
            end
        end else begin
            next_s = digit_r;
            co     = 1'b0;
        end
    end

    // Digit register; load wins over a step in the same cycle
    always_ff @(posedge tg or negedge rst_n) begin
        if (!rst_n) begin
            digit_r <= 4'd0;
        end else if (load) begin
            digit_r <= ld_clean_s;
        end else begin
            digit_r <= next_s;
        end
    end

    assign q = digit_r;

endmodule

// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with a multiplexed 7-segment scan driver.
// Count and scan rates come from clock-enable prescalers on the single clock tg.
module bcd_scan_counter
    import display_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int TICK_DIV       = 262144,
    parameter int SCAN_DIV       = 32768,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  tg,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig
);

    localparam int CNT_W  = clog2(TICK_DIV);
    localparam int SCAN_W = clog2(SCAN_DIV);
    localparam int IDX_W  = clog2(DIGITS);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    localparam bit SEG_INV = (SEG_ACTIVE_LOW != 32'sd0);
    localparam bit DIG_INV = (DIG_ACTIVE_LOW != 32'sd0);

    // Idle (all-inactive) output levels in the selected polarity
    localparam logic [6:0]        SEG_IDLE = SEG_INV ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_IDLE = DIG_INV ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    cnt_pre_r;
    logic [SCAN_W-1:0]   scan_pre_r;
    logic [IDX_W-1:0]    scan_idx_r;
    logic                cnt_tick_s;
    logic                scan_tick_s;
    logic [DIGITS:0]     carry_s;
    logic [4*DIGITS-1:0] digits_s;
    logic                wrap_r;

    logic [DIGITS-1:0]   blank_s;
    logic [DIGITS-1:0]   dig_onehot_s;
    logic                zero_above_s;
    bcd_t                sel_digit_s;
    logic                sel_blank_s;
    logic [6:0]          seg_pat_s;
    logic [6:0]          seg_r;
    logic [DIGITS-1:0]   dig_r;

    // Count tick only fires while enabled, so a held prescaler never ticks
    assign cnt_tick_s  = en && (cnt_pre_r == CNT_LAST);
    assign scan_tick_s = (scan_pre_r == SCAN_LAST);

    // Count prescaler: cleared by load, holds while disabled
    always_ff @(posedge tg or negedge rst_n) begin
        if (!rst_n) begin
            cnt_pre_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_pre_r <= {CNT_W{1'b0}};
        end else if (cnt_tick_s) begin
            cnt_pre_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_pre_r <= cnt_pre_r + CNT_W'(1);
        end else begin
            cnt_pre_r <= cnt_pre_r;
        end
    end

    // Scan prescaler: free-running
    always_ff @(posedge tg or negedge rst_n) begin
        if (!rst_n) begin
            scan_pre_r <= {SCAN_W{1'b0}};
        end else if (scan_tick_s) begin
            scan_pre_r <= {SCAN_W{1'b0}};
        end else begin
            scan_pre_r <= scan_pre_r + SCAN_W'(1);
        end
    end

    // Scan index walks 0..DIGITS-1 and back to 0 on each scan tick
    always_ff @(posedge tg or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_r <= {IDX_W{1'b0}};
        end else if (scan_tick_s) begin
            if (scan_idx_r == IDX_LAST) begin
                scan_idx_r <= {IDX_W{1'b0}};
            end else begin
                scan_idx_r <= scan_idx_r + IDX_W'(1);
            end
        end else begin
            scan_idx_r <= scan_idx_r;
        end
    end

    // Digit chain: digit 0 is stepped by the tick, the rest by carry/borrow
    assign carry_s[0] = cnt_tick_s;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .tg     (tg),
                .rst_n  (rst_n),
                .ci     (carry_s[g]),
                .up     (up),
                .load   (load),
                .ld_val (load_val[4*g +: 4]),
                .q      (digits_s[4*g +: 4]),
                .co     (carry_s[g+1])
            );
        end
    endgenerate

    // Wrap pulse: carry/borrow out of the top digit, suppressed by a concurrent load
    always_ff @(posedge tg or negedge rst_n) begin
        if (!rst_n) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= cnt_tick_s && !load && carry_s[DIGITS];
        end
    end

    // Leading-zero mask, scan one-hot and selected-digit mux
    always_comb begin
        zero_above_s = 1'b1;
        blank_s      = {DIGITS{1'b0}};
        dig_onehot_s = {DIGITS{1'b0}};
        sel_digit_s  = 4'd0;
        sel_blank_s  = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above_s = zero_above_s && (digits_s[4*k +: 4] == 4'd0);
            blank_s[k]   = blank_lz && zero_above_s;
        end
        for (int k = 0; k < DIGITS; k++) begin
            dig_onehot_s[k] = (scan_idx_r == IDX_W'(k));
            sel_digit_s     = sel_digit_s | (digits_s[4*k +: 4] & {4{dig_onehot_s[k]}});
            sel_blank_s     = sel_blank_s | (blank_s[k] & dig_onehot_s[k]);
        end
        seg_pat_s = sel_blank_s ? SEG_BLANK : bcd_to_seg(sel_digit_s);
    end

    // Output registers: seg and dig update together; polarity applied only here
    always_ff @(posedge tg or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_IDLE;
            dig_r <= DIG_IDLE;
        end else begin
            seg_r <= SEG_INV ? ~seg_pat_s : seg_pat_s;
            dig_r <= DIG_INV ? ~dig_onehot_s : dig_onehot_s;
        end
    end

    assign count = digits_s;
    assign wrap  = wrap_r;
    assign seg   = seg_r;
    assign dig   = dig_r;

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Parametrised N-digit BCD counter with a built-in multiplexed 7-segment scan driver. It is the successor to the fixed 4-digit, 0–9999 up-counter and display pair. It replaces derived clocks with clock-enable ticks, and adds:
- up/down counting
- parallel load
- a wrap flag
- leading-zero blanking
- selectable output polarity

It sits between the board clock `tg` and the digit-select/segment pins.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits; legal range 1..8.
- `TICK_DIV`, 262144: `tg` cycles per count step; must be ≥ 2.
- `SCAN_DIV`, 32768: `tg` cycles per digit-scan step; must be ≥ 2.
- `SEG_ACTIVE_LOW`, 0: 1 inverts `seg`.
- `DIG_ACTIVE_LOW`, 0: 1 inverts `dig`.

Ports:
- `tg`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: count enable.
- `up`, in, 1: direction; 1 counts up, 0 counts down.
- `load`, in, 1: synchronous parallel load strobe.
- `load_val`, in, 4*DIGITS: BCD value; nibble k is digit k, and digit 0 is least significant.
- `blank_lz`, in, 1: blank leading zeros.
- `count`, out, 4*DIGITS: current BCD value.
- `wrap`, out, 1: one-cycle pulse on full-scale wrap.
- `seg`, out, 7: segments; bit0=A (top), bit1=B, bit2=C, bit3=D, bit4=E, bit5=F, bit6=G (middle).
- `dig`, out, DIGITS: one-hot digit select; `dig[DIGITS-1]` is the most significant (leftmost) digit.

## Operation
- **Count prescaler:**
  - Advances only while `en`=1 and holds its value while `en`=0.
  - Emits a 1-cycle `cnt_tick` at terminal value `TICK_DIV-1`, then returns to 0.
- **Scan prescaler:** free-runs and emits a 1-cycle `scan_tick` at `SCAN_DIV-1`.
- **Count step** (on `cnt_tick`):
  - Up: each digit increments when its carry-in is set; 9→0 generates a carry.
  - Down: each digit decrements when its borrow-in is set; 0→9 generates a borrow.
  - Digit 0 always receives carry/borrow-in on a tick.
- **Wrap:**
  - Up from all-9s goes to all-0s; down from all-0s goes to all-9s.
  - Either case asserts `wrap` for exactly one cycle.
- **Load:**
  - `load`=1 copies `load_val` into `count` and clears the count prescaler.
  - Any nibble greater than 9 is stored as 0.
  - Load has priority over a simultaneous `cnt_tick`: that tick is discarded and `wrap` stays 0.
- **Direction:** `up` is sampled on the tick cycle only.
- **Scan:**
  - The digit index advances 0,1,…,DIGITS-1,0 on `scan_tick`.
  - `dig` drives the index one-hot, and `seg` drives that digit's pattern.
- **Segment patterns (active-high):** 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- **Blanking:**
  - With `blank_lz`=1, digit k > 0 is blanked when digits k..DIGITS-1 are all 0.
  - A blanked digit drives `seg`=0x00 (active-high sense) while `dig` still scans.
  - Digit 0 is never blanked.
- **Polarity:** inversion is applied at the output registers only.

## Timing
- **Reset:**
  - `count`=0, both prescalers=0, scan index=0, `wrap`=0.
  - `seg` and `dig` are all-inactive (0 if active-high, all-1 if active-low).
- **First edge after `rst_n` rises:** `dig` selects digit 0 and `seg` shows "0".
- **Count latency:** `count` updates on the edge where `cnt_tick`=1; `wrap` is registered on that same edge.
- **`seg`/`dig`:** registered outputs, updated every cycle from the current `count`, index and `blank_lz`. Two consequences:
  - Display changes lag a `count` change by 1 cycle.
  - `seg` and `dig` always change on the same edge, so there is no ghosting skew.
- **Load:** `count` equals the sanitised `load_val` on the edge after `load` is sampled.
- **Reset mid-operation:** all registers return to reset values immediately (asynchronously); a partial count step is lost.
- **Steady-state count period:** `TICK_DIV` cycles with `en` continuously high.

## Structure
- **Shared package `display_pkg`:**
  - the segment-pattern constants `SEG_0`..`SEG_9` and `SEG_BLANK`;
  - function `bcd_to_seg` (4-bit BCD to 7-bit pattern);
  - the clog2 helper for prescaler widths.
- **Sub-module `bcd_digit`:** one 4-bit up/down digit with `ci` (carry/borrow-in), `up`, `load`, `ld_val` and `co`. Instantiate it DIGITS times in a generate chain.
- **Prescalers, scan index and output registers:** live in the top level.

## Test plan
All scenarios use DIGITS=4, TICK_DIV=4, SCAN_DIV=2 unless stated.
- **Reset:**
  - Stimulus: assert `rst_n`=0 mid-count.
  - Response: `count`=0x0000, `seg`=0, `dig`=0 and `wrap`=0 immediately. One edge after release: `dig`=0001, `seg`=0x3F.
- **Up wrap:**
  - Stimulus: load 0x9998, then `en`=1, `up`=1.
  - Response: after 4 cycles 0x9999; after 4 more 0x0000 with `wrap` high for exactly 1 cycle.
- **Down borrow:**
  - Stimulus: load 0x1000, `up`=0.
  - Response: first tick gives 0x0999. Load 0x0000 and tick: 0x9999 with a `wrap` pulse.
- **Load priority and sanitising:**
  - Stimulus: assert `load` with `load_val`=0x12AF on a `cnt_tick` cycle.
  - Response: `count`=0x1200, no `wrap`, and the next tick arrives 4 cycles later.
- **Blanking and scan:**
  - Stimulus: `count`=0x0042, `blank_lz`=1.
  - Response: over one 8-cycle scan, digit0 shows 0x5B ("2"), digit1 shows 0x66 ("4"), and digits 2 and 3 show 0x00. Stimulus 0x0000: only digit0 lit, showing 0x3F.
- **Polarity and enable:**
  - Stimulus: `SEG_ACTIVE_LOW`=1, `DIG_ACTIVE_LOW`=1, digit "8".
  - Response: `seg`=0x00 and the `dig` select bit=0. With `en`=0 for 20 cycles, `count` is unchanged and the prescaler resumes from its held value.
